// File: rtl/race_arbiter_array.sv
// race_arbiter_array: per-channel A/B arrival-order race arbiter collecting RESP_W response bits per run
module race_arbiter_array #(
  parameter int N_CH = 4,
  parameter int RESP_W = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_CH-1:0]          a,
  input  logic [N_CH-1:0]          b,
  output logic                     launch,
  output logic                     busy,
  output logic [N_CH*RESP_W-1:0]   resp_data,
  output logic [N_CH-1:0]          tie_flags,
  output logic [N_CH-1:0]          timeout_flags,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     done
);
  localparam int CW = $clog2(RESP_W + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, RACE, SHIFT, RECOVER, HOLD} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0] a_m_q, a_s_q, b_m_q, b_s_q;
  logic [N_CH-1:0] res_q, res_d, bit_q, bit_d, tie_q, tie_d, to_q, to_d, hit;
  logic [N_CH*RESP_W-1:0] resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic done_q, done_d, race_end;
  always_comb begin
    hit = ~res_q & (a_s_q | b_s_q);
    race_end = (&(res_q | hit)) || (tmr_q == 16'(TIMEOUT - 1));
    state_d = state_q;
    res_d = res_q;
    bit_d = bit_q;
    tie_d = tie_q;
    to_d = to_q;
    resp_d = resp_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cnt_d = '0;
        tie_d = '0;
        to_d = '0;
        resp_d = '0;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        tmr_d = '0;
        res_d = '0;
        bit_d = '0;
        state_d = RACE;
      end
      RACE: begin
        tmr_d = tmr_q + 16'd1;
        res_d = res_q | hit;
        bit_d = bit_q | (hit & a_s_q & ~b_s_q);
        tie_d = tie_q | (hit & a_s_q & b_s_q);
        to_d = race_end ? (to_q | ~(res_q | hit)) : to_q;
        state_d = race_end ? SHIFT : RACE;
      end
      SHIFT: begin
        for (int i = 0; i < N_CH; i++)
          resp_d[i*RESP_W +: RESP_W] = (resp_q[i*RESP_W +: RESP_W] << 1) | RESP_W'(bit_q[i]);
        cnt_d = cnt_q + 1'b1;
        state_d = RECOVER;
      end
      RECOVER: if (!(|(a_s_q | b_s_q))) state_d = (cnt_q == CW'(RESP_W)) ? HOLD : LAUNCH;
      HOLD: if (resp_ready) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_m_q <= '0;
      a_s_q <= '0;
      b_m_q <= '0;
      b_s_q <= '0;
      res_q <= '0;
      bit_q <= '0;
      tie_q <= '0;
      to_q <= '0;
      resp_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_m_q <= a;
      a_s_q <= a_m_q;
      b_m_q <= b;
      b_s_q <= b_m_q;
      res_q <= res_d;
      bit_q <= bit_d;
      tie_q <= tie_d;
      to_q <= to_d;
      resp_q <= resp_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      done_q <= done_d;
    end
  end
  assign launch = state_q == LAUNCH;
  assign busy = state_q != IDLE;
  assign resp_valid = state_q == HOLD;
  assign done = done_q;
  assign resp_data = resp_q;
  assign tie_flags = tie_q;
  assign timeout_flags = to_q;
endmodule

// File: tb/tb_race_arbiter_array.sv
// tb_race_arbiter_array: table-driven race vectors plus backpressure, stuck-input and mid-run reset sequences
module tb_race_arbiter_array;
  localparam int N = 2, W = 4, TO = 16;
  localparam logic [1:0] A = 2'd0, B = 2'd1, T = 2'd2, X = 2'd3;
  typedef struct packed {
    logic [7:0] c0, c1, resp;
    logic [1:0] tie, to;
    logic [7:0] gap;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, resp_ready = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic launch, busy, resp_valid, done;
  logic [N*W-1:0] resp_data;
  logic [N-1:0] tie_flags, timeout_flags;
  int n_cmp = 0, n_bad = 0, cyc = 0, launch_cnt = 0, last_launch = 0, dbl = 0;
  logic launch_prev = 1'b0;
  vec_t vt [5];

  race_arbiter_array #(.N_CH(N), .RESP_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .launch(launch), .busy(busy),
    .resp_data(resp_data), .tie_flags(tie_flags), .timeout_flags(timeout_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (launch) begin
      launch_cnt++;
      last_launch = cyc;
      if (launch_prev) dbl++;
    end
    launch_prev = launch;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [7:0] pk(logic [1:0] e0, logic [1:0] e1, logic [1:0] e2, logic [1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_launch(string nm);
    int t = 0;
    while (!launch && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_launch_seen"}, 32'(launch), 1);
  endtask

  task automatic drive_eval(logic [1:0] p0, logic [1:0] p1, int stick, string nm);
    logic [1:0] p [2];
    int l0;
    p[0] = p0;
    p[1] = p1;
    wait_launch(nm);
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      a[c] = (p[c] == A) || (p[c] == T);
      b[c] = (p[c] == B) || (p[c] == T);
    end
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      if (p[c] == A) b[c] = 1'b1;
      if (p[c] == B) a[c] = 1'b1;
    end
    repeat (3) @(negedge clk);
    if (stick > 0) begin
      l0 = launch_cnt;
      b = '0;
      a = 2'b01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (stick - 1) @(negedge clk);
      chk({nm, "_stuck_no_launch"}, launch_cnt, l0);
      chk({nm, "_stuck_busy"}, 32'(busy), 1);
    end
    a = '0;
    b = '0;
  endtask

  task automatic run_vec(vec_t v, int bp, int stick, string nm);
    int l1 = 0, t = 0;
    bit ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < 4; e++) begin
      drive_eval(v.c0[2*e +: 2], v.c1[2*e +: 2], e == 0 ? stick : 0, nm);
      if (e == 0) l1 = last_launch;
      if (e == 1 && v.gap != 0) chk({nm, "_launch_gap"}, last_launch - l1, 32'(v.gap));
    end
    while (!resp_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_resp_valid"}, 32'(resp_valid), 1);
    chk({nm, "_resp_data"}, 32'(resp_data), 32'(v.resp));
    chk({nm, "_tie_flags"}, 32'(tie_flags), 32'(v.tie));
    chk({nm, "_timeout_flags"}, 32'(timeout_flags), 32'(v.to));
    repeat (bp + 1) begin
      if (!(resp_valid && busy && !done && resp_data == v.resp && tie_flags == v.tie && timeout_flags == v.to)) ok = 1'b0;
      @(negedge clk);
    end
    chk({nm, "_hold_stable"}, 32'(ok), 1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_done_pulse"}, 32'(done), 1);
    chk({nm, "_idle_busy"}, 32'(busy), 0);
    chk({nm, "_idle_valid"}, 32'(resp_valid), 0);
    @(negedge clk);
    chk({nm, "_done_single"}, 32'(done), 0);
    chk({nm, "_data_retained"}, 32'(resp_data), 32'(v.resp));
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_launch"}, 32'(launch), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_valid"}, 32'(resp_valid), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_data"}, 32'(resp_data), 0);
    chk({nm, "_flags"}, 32'({tie_flags, timeout_flags}), 0);
  endtask

  initial begin
    vt[0] = '{pk(A, A, A, A), pk(B, B, B, B), 8'h0F, 2'b00, 2'b00, 8'd0};
    vt[1] = '{pk(A, T, A, A), pk(B, B, B, B), 8'h0B, 2'b01, 2'b00, 8'd0};
    vt[2] = '{pk(A, A, A, A), pk(X, X, X, X), 8'h0F, 2'b00, 2'b10, 8'd19};
    vt[3] = '{pk(A, B, A, B), pk(B, A, B, A), 8'h5A, 2'b00, 2'b00, 8'd0};
    vt[4] = '{pk(X, X, X, X), pk(B, B, B, T), 8'h00, 2'b10, 2'b01, 8'd0};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_vec(vt[i], i == 0 ? 10 : 0, 0, $sformatf("v%0d", i));
    run_vec(vt[0], 0, 20, "stuck");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_eval(A, B, 0, "mid_e1");
    drive_eval(A, B, 0, "mid_e2");
    wait_launch("mid_e3");
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 1);
    a = '0;
    b = '0;
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    chk_zero("mid_rst_held");
    rst = 1'b0;
    run_vec(vt[0], 0, 0, "after_rst");
    chk("launch_one_cycle", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
